// File: rtl/roc_frame_deser_pkg.sv
// Shared constants and types for the ROC frame deserializer and its header detector.
package roc_frame_pkg;

  localparam int unsigned WORD_W_DEF    = 12;
  localparam int unsigned SYNC_W        = 12;
  localparam int unsigned MAX_WORDS_DEF = 64;

  localparam logic [SYNC_W-1:0] SYNC_DEF    = 12'b0111_1111_1100;
  localparam logic [11:0]       TRAILER_DEF = 12'b0111_1111_1110;

  typedef enum logic {
    HUNT,
    DATA
  } state_e;

endpackage

// File: rtl/roc_frame_deser_if.sv
// Word output channel of the frame deserializer towards the readout FIFO.
interface roc_frame_deser_if
  import roc_frame_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
);

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_first;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_first,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_first,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/roc_frame_deser_sync_detect.sv
// Serial header detector: sliding window over the bit stream, hit is combinational on the shifted value.
module roc_sync_detect
  import roc_frame_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC = SYNC_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic din,
  input  logic bit_en,
  output logic sync_hit
);

  // Only the older bits are stored; the newest bit of the window is din itself.
  logic [SYNC_W-2:0] sr_q, sr_d;
  logic [SYNC_W-1:0] window;

  always_comb begin
    window   = {sr_q, din};
    sr_d     = sr_q;
    sync_hit = 1'b0;
    if (bit_en) begin
      sr_d     = window[SYNC_W-2:0];
      sync_hit = (window == SYNC);
    end
  end

  always_ff @(posedge clk) begin
    if (res) sr_q <= '0;
    else     sr_q <= sr_d;
  end

endmodule

// File: rtl/roc_frame_deser.sv
// ROC frame deserializer: hunts for the header, assembles words until trailer or length
// limit, and presents them through a one-entry valid/ready output register.
module roc_frame_deser
  import roc_frame_pkg::*;
#(
  parameter int unsigned       WORD_W    = WORD_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC      = SYNC_DEF,
  parameter logic [WORD_W-1:0] TRAILER   = WORD_W'(TRAILER_DEF),
  parameter int unsigned       MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     din,
  input  logic                     bit_en,
  roc_frame_deser_if.master        out_if,
  output logic                     frame_err,
  output logic                     ovf
);

  localparam int unsigned BCNT_W = $clog2(WORD_W);
  localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);

  state_e              state_q, state_d;
  logic [WORD_W-2:0]   wsr_q, wsr_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                first_q, first_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_first_q, out_first_d;
  logic                out_last_q, out_last_d;
  logic                frame_err_q, frame_err_d;
  logic                ovf_q, ovf_d;

  logic                sync_hit;
  logic [WORD_W-1:0]   word;
  logic [WCNT_W-1:0]   wcnt_inc;
  logic                at_limit;
  logic                is_trailer;
  logic                can_load;

  roc_sync_detect #(
    .SYNC(SYNC)
  ) u_sync (
    .clk     (clk),
    .res     (res),
    .din     (din),
    .bit_en  (bit_en),
    .sync_hit(sync_hit)
  );

  always_comb begin
    state_d     = state_q;
    wsr_d       = wsr_q;
    bcnt_d      = bcnt_q;
    wcnt_d      = wcnt_q;
    first_d     = first_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_if.out_ready;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    frame_err_d = 1'b0;
    ovf_d       = 1'b0;

    word       = {wsr_q, din};
    wcnt_inc   = wcnt_q + 1'b1;
    at_limit   = (wcnt_inc == WCNT_W'(MAX_WORDS));
    is_trailer = (word == TRAILER);
    // A slot frees up in the same cycle the held word is taken, so loads never bubble.
    can_load   = !out_valid_q || out_if.out_ready;

    case (state_q)
      HUNT: begin
        bcnt_d  = '0;
        wcnt_d  = '0;
        first_d = 1'b1;
        if (sync_hit) state_d = DATA;
      end
      DATA: begin
        if (bit_en) begin
          wsr_d = word[WORD_W-2:0];
          if (bcnt_q == BCNT_W'(WORD_W - 1)) begin
            bcnt_d = '0;
            wcnt_d = wcnt_inc;
            if (can_load) begin
              out_data_d  = word;
              out_valid_d = 1'b1;
              out_first_d = first_q;
              out_last_d  = is_trailer || at_limit;
              first_d     = 1'b0;
              frame_err_d = at_limit && !is_trailer;
              if (is_trailer || at_limit) state_d = HUNT;
            end else begin
              ovf_d   = 1'b1;
              state_d = HUNT;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= HUNT;
      wsr_q       <= '0;
      bcnt_q      <= '0;
      wcnt_q      <= '0;
      first_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wsr_q       <= wsr_d;
      bcnt_q      <= bcnt_d;
      wcnt_q      <= wcnt_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_first = out_first_q;
  assign out_if.out_last  = out_last_q;
  assign frame_err        = frame_err_q;
  assign ovf              = ovf_q;

endmodule
